// File: rtl/ham_scrub_pkg.sv
// Shared definitions for the Hamming(15,11) RAM scrubber.
// Codeword bit i holds Hamming position i+1; parity bits sit at positions 1, 2, 4, 8.
package ham_scrub_pkg;

    localparam int HAM_N  = 15;
    localparam int HAM_K  = 11;
    localparam int RD_LAT = 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_NEXT  = 3'd5;

    // XOR of the 1-based positions of all set bits; zero for a valid codeword.
    function automatic logic [3:0] ham_syndrome(input logic [HAM_N-1:0] w);
        logic [3:0] s;
        s = '0;
        for (int unsigned i = 0; i < HAM_N; i++) begin
            if (w[i]) s = s ^ 4'(i + 1);
        end
        return s;
    endfunction

endpackage

// File: rtl/ham_15_11_check.sv
// Hamming(15,11) encoder, decoder and the decode/re-encode checker used by the scrubber.
module ham_15_11_enc
    import ham_scrub_pkg::*;
(
    input  logic [HAM_K-1:0] data,
    output logic [HAM_N-1:0] code
);
    // Scatter data into non-power-of-two positions, then fill parity from the syndrome.
    always_comb begin
        int unsigned j;
        logic [3:0]  syn;
        code = '0;
        j    = 0;
        for (int unsigned i = 0; i < HAM_N; i++) begin
            if (((i + 1) & i) != 0) begin
                code[i] = data[j];
                j++;
            end
        end
        syn     = ham_syndrome(code);
        code[0] = syn[0];
        code[1] = syn[1];
        code[3] = syn[2];
        code[7] = syn[3];
    end
endmodule

module ham_15_11_dec
    import ham_scrub_pkg::*;
(
    input  logic [HAM_N-1:0] code,
    output logic [HAM_K-1:0] data
);
    // Flip the bit named by the syndrome, then gather the data positions.
    always_comb begin
        int unsigned j;
        logic [3:0]  syn;
        logic [HAM_N-1:0] fixed;
        syn   = ham_syndrome(code);
        fixed = code;
        for (int unsigned i = 0; i < HAM_N; i++) begin
            if (syn == 4'(i + 1)) fixed[i] = ~fixed[i];
        end
        data = '0;
        j    = 0;
        for (int unsigned i = 0; i < HAM_N; i++) begin
            if (((i + 1) & i) != 0) begin
                data[j] = fixed[i];
                j++;
            end
        end
    end
endmodule

module ham_15_11_check
    import ham_scrub_pkg::*;
(
    input  logic [HAM_N-1:0] raw,
    output logic [HAM_N-1:0] fixed,
    output logic             mismatch
);
    logic [HAM_K-1:0] data;

    ham_15_11_dec u_dec (.code(raw),  .data(data));
    ham_15_11_enc u_enc (.data(data), .code(fixed));

    assign mismatch = (fixed != raw);
endmodule

// File: rtl/ham_15_11_scrubber.sv
// Background scrubber: reads each RAM word, re-encodes it and writes back any correction.
// Optional build macro SCRUB_CONTINUOUS_EN: wrap to address 0 after the last word instead of idling.
module ham_15_11_scrubber
    import ham_scrub_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              mem_grant_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    input  logic [14:0]       mem_rdata_i,
    output logic              mem_wr_o,
    output logic [14:0]       mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic [CNT_W-1:0]  corr_cnt_o
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [14:0]       raw_r;
    logic [14:0]       fix_r;
    logic [14:0]       chk_fixed;
    logic              chk_mismatch;

    ham_15_11_check u_check (
        .raw      (raw_r),
        .fixed    (chk_fixed),
        .mismatch (chk_mismatch)
    );

    // Strobes are also masked by rst_i so a reset cycle never issues a RAM access.
    assign mem_rd_o    = (state == ST_READ)  && mem_grant_i && !rst_i;
    assign mem_wr_o    = (state == ST_WRITE) && mem_grant_i && !rst_i;
    assign mem_wdata_o = (state == ST_WRITE) ? fix_r : '0;
    assign mem_addr_o  = addr;
    assign busy_o      = (state != ST_IDLE);

    // Scrub sequencer, status pulses and correction bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            addr       <= '0;
            raw_r      <= '0;
            fix_r      <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_addr_o <= '0;
            corr_cnt_o <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        addr  <= '0;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (mem_grant_i) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    raw_r <= mem_rdata_i;
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    fix_r <= chk_fixed;
                    state <= chk_mismatch ? ST_WRITE : ST_NEXT;
                end
                ST_WRITE: begin
                    if (mem_grant_i) begin
                        err_o      <= 1'b1;
                        err_addr_o <= addr;
                        if (corr_cnt_o != '1) corr_cnt_o <= corr_cnt_o + CNT_W'(1);
                        state      <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (addr == LAST) begin
                        done_o <= 1'b1;
`ifdef SCRUB_CONTINUOUS_EN
                        if (stop_i) begin
                            state <= ST_IDLE;
                        end else begin
                            addr  <= '0;
                            state <= ST_READ;
                        end
`else
                        state <= ST_IDLE;
`endif
                    end else if (stop_i) begin
                        state <= ST_IDLE;
                    end else begin
                        addr  <= addr + ADDR_W'(1);
                        state <= ST_READ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ham_15_11_scrubber.sv
// Self-checking bench for ham_15_11_scrubber with a 4-word RAM model and a write scoreboard.
module tb_ham_15_11_scrubber;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;
    localparam logic [14:0] GOOD = 15'b110_0011_0101_0000;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic              stop_i = 1'b0;
    logic              mem_grant_i = 1'b1;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_rd_o;
    logic [14:0]       mem_rdata_i = '0;
    logic              mem_wr_o;
    logic [14:0]       mem_wdata_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [ADDR_W-1:0] err_addr_o;
    logic [CNT_W-1:0]  corr_cnt_o;

    ham_15_11_scrubber #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .mem_grant_i (mem_grant_i),
        .mem_addr_o  (mem_addr_o),
        .mem_rd_o    (mem_rd_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_wr_o    (mem_wr_o),
        .mem_wdata_o (mem_wdata_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_addr_o  (err_addr_o),
        .corr_cnt_o  (corr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int tests_run = 0;
    int tests_failed = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    logic [14:0] mem [DEPTH];
    typedef struct { logic [ADDR_W-1:0] a; logic [14:0] d; } wr_t;
    wr_t exp_q[$];
    logic              rd_pend = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;

    // Reference correction: flip the bit whose 1-based position equals the syndrome.
    function automatic logic [14:0] model_fix(input logic [14:0] w);
        int s;
        s = 0;
        for (int i = 0; i < 15; i++) if (w[i]) s = s ^ (i + 1);
        if (s != 0) w[s-1] = ~w[s-1];
        return w;
    endfunction

    // RAM model and scoreboard, sampled mid-cycle after the drivers have settled.
    always @(negedge clk_i) begin
        wr_t e;
        #2;
        rd_pend = mem_rd_o;
        rd_addr = mem_addr_o;
        if (mem_rd_o || mem_wr_o) begin
            tests_run++;
            if (mem_rd_o && mem_wr_o) begin
                tests_failed++;
                $display("FAIL strobe_excl rd=%b wr=%b, required not both high", mem_rd_o, mem_wr_o);
            end
        end
        if (mem_wr_o) begin
            wr_cnt++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_write addr=%0d data=%h, required no write", mem_addr_o, mem_wdata_o);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr_o !== e.a || mem_wdata_o !== e.d) begin
                    tests_failed++;
                    $display("FAIL write addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr_o, mem_wdata_o, e.a, e.d);
                end
            end
            mem[int'(mem_addr_o)] = mem_wdata_o;
        end
        if (done_o) done_cnt++;
        if (err_o) err_cnt++;
    end

    // Read data is valid only in the cycle after an accepted read.
    always @(posedge clk_i) mem_rdata_i <= rd_pend ? mem[int'(rd_addr)] : 15'h2aaa;

    task automatic load(input logic [14:0] w0, input logic [14:0] w1,
                        input logic [14:0] w2, input logic [14:0] w3);
        logic [14:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 4; i++) begin
            mem[i] = w[i];
            if (model_fix(w[i]) != w[i]) exp_q.push_back('{a: ADDR_W'(i), d: model_fix(w[i])});
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk_i);
        #3;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic run_pass(input int budget, output int n);
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        n = 0;
        while (!done_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        tests_run++;
        if (n >= budget) begin
            tests_failed++;
            $display("FAIL pass_timeout cycles=%0d, required done within %0d", n, budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i); rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        mem_grant_i = 1'b1;
        do_reset();
        #1;
        check_int("reset_strobes", int'({busy_o, done_o, err_o, mem_rd_o, mem_wr_o}), 0);
        check_int("reset_err_addr", int'(err_addr_o), 0);
        check_int("reset_corr_cnt", int'(corr_cnt_o), 0);
        check_int("reset_mem_addr", int'(mem_addr_o), 0);
        check_int("reset_wdata", int'(mem_wdata_o), 0);
    endtask

    task automatic test_clean();
        int n, w0, d0;
        load(GOOD, GOOD, GOOD, GOOD);
        w0 = wr_cnt; d0 = done_cnt;
        run_pass(60, n);
        settle();
        check_int("clean_cycles", n, 16);
        check_int("clean_writes", wr_cnt - w0, 0);
        check_int("clean_corr_cnt", int'(corr_cnt_o), 0);
        check_int("clean_done", done_cnt - d0, 1);
        check_int("clean_busy", int'(busy_o), 0);
    endtask

    task automatic test_single_bit();
        int n, w0, e0;
        logic [14:0] flip [2];
        flip[0] = GOOD ^ 15'h0001;
        flip[1] = 15'b010_0011_0101_0000;
        for (int k = 0; k < 2; k++) begin
            load(GOOD, GOOD, flip[k], GOOD);
            w0 = wr_cnt; e0 = err_cnt;
            run_pass(60, n);
            settle();
            check_int("single_cycles", n, 17);
            check_int("single_writes", wr_cnt - w0, 1);
            check_int("single_err_pulses", err_cnt - e0, 1);
            check_int("single_err_addr", int'(err_addr_o), 2);
            check_int("single_corr_cnt", int'(corr_cnt_o), k + 1);
            check_int("single_mem2", int'(mem[2]), int'(GOOD));
            check_int("single_queue_empty", exp_q.size(), 0);
        end
    endtask

    task automatic test_grant();
        int n, w0;
        load(GOOD, GOOD, GOOD ^ 15'h0020, GOOD);
        w0 = wr_cnt;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        n = 0;
        while (!done_o && n < 80) begin
            mem_grant_i = !((n <= 4) || (n >= 16 && n <= 20));
            #1;
            if (n == 2) begin
                check_int("grant_read_strobe", int'(mem_rd_o), 0);
                check_int("grant_read_addr", int'(mem_addr_o), 0);
            end
            if (n == 18) begin
                check_int("grant_write_strobe", int'(mem_wr_o), 0);
                check_int("grant_write_addr", int'(mem_addr_o), 2);
                check_int("grant_write_busy", int'(busy_o), 1);
            end
            @(negedge clk_i);
            n++;
        end
        mem_grant_i = 1'b1;
        settle();
        check_int("grant_cycles", n, 27);
        check_int("grant_writes", wr_cnt - w0, 1);
        check_int("grant_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_stop();
        int n, w0, d0;
        load(GOOD, GOOD ^ 15'h0200, GOOD, GOOD);
        w0 = wr_cnt; d0 = done_cnt;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        n = 0;
        while (busy_o && n < 60) begin
            if (n == 5) stop_i = 1'b1;
            @(negedge clk_i);
            n++;
        end
        #1;
        check_int("stop_cycles", n, 9);
        check_int("stop_busy", int'(busy_o), 0);
        check_int("stop_addr", int'(mem_addr_o), 1);
        stop_i = 1'b0;
        settle();
        check_int("stop_writes", wr_cnt - w0, 1);
        check_int("stop_no_done", done_cnt - d0, 0);
        check_int("stop_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_start_ignored();
        int n, d0;
        load(GOOD, GOOD, GOOD, GOOD);
        d0 = done_cnt;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        n = 0;
        while (!done_o && n < 60) begin
            start_i = (n == 6);
            #1;
            if (n == 8) begin
                check_int("restart_addr", int'(mem_addr_o), 2);
                check_int("restart_rd", int'(mem_rd_o), 1);
            end
            @(negedge clk_i);
            n++;
        end
        start_i = 1'b0;
        settle();
        check_int("restart_cycles", n, 16);
        check_int("restart_done", done_cnt - d0, 1);
        check_int("restart_idle", int'(busy_o), 0);
    endtask

    task automatic test_reset_mid();
        int w0;
        load(GOOD, GOOD, GOOD, GOOD ^ 15'h0008);
        exp_q.delete();
        w0 = wr_cnt;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        repeat (15) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_int("rstmid_wr_masked", int'(mem_wr_o), 0);
        check_int("rstmid_in_write", int'(busy_o), 1);
        @(negedge clk_i);
        #1;
        check_int("rstmid_strobes", int'({busy_o, done_o, err_o, mem_rd_o, mem_wr_o}), 0);
        check_int("rstmid_corr_cnt", int'(corr_cnt_o), 0);
        check_int("rstmid_err_addr", int'(err_addr_o), 0);
        check_int("rstmid_addr", int'(mem_addr_o), 0);
        rst_i = 1'b0;
        settle();
        check_int("rstmid_writes", wr_cnt - w0, 0);
        check_int("rstmid_mem3", int'(mem[3]), int'(GOOD ^ 15'h0008));
    endtask

    task automatic test_saturate();
        int n, w0, e0;
        do_reset();
        load(GOOD ^ 15'h0001, GOOD ^ 15'h0010, GOOD ^ 15'h0080, GOOD ^ 15'h1000);
        w0 = wr_cnt; e0 = err_cnt;
        run_pass(60, n);
        settle();
        check_int("sat_cycles", n, 20);
        check_int("sat_corr_cnt_4", int'(corr_cnt_o), 3);
        load(GOOD, GOOD ^ 15'h0800, GOOD, GOOD);
        run_pass(60, n);
        settle();
        check_int("sat_corr_cnt_5", int'(corr_cnt_o), 3);
        check_int("sat_err_pulses", err_cnt - e0, 5);
        check_int("sat_writes", wr_cnt - w0, 5);
        check_int("sat_err_addr", int'(err_addr_o), 1);
    endtask

    task automatic test_continuous();
        int n, first_done, second_done;
        load(GOOD, GOOD, GOOD, GOOD ^ 15'h0002);
        first_done = -1; second_done = -1;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        n = 0;
        while (n < 40) begin
            #1;
            if (done_o && first_done < 0) first_done = n;
            else if (done_o && second_done < 0) second_done = n;
            if (n == 17) begin
                check_int("cont_wrap_addr", int'(mem_addr_o), 0);
                check_int("cont_busy", int'(busy_o), 1);
            end
            @(negedge clk_i);
            n++;
        end
        check_int("cont_first_done", first_done, 17);
        check_int("cont_second_done", second_done, 33);
        stop_i = 1'b1;
        n = 0;
        while (busy_o && n < 30) begin @(negedge clk_i); n++; end
        stop_i = 1'b0;
        check_int("cont_stop_idle", int'(busy_o), 0);
        settle();
        check_int("cont_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout, required bench to finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
`ifdef SCRUB_CONTINUOUS_EN
        test_continuous();
`else
        test_clean();
        test_single_bit();
        test_grant();
        test_stop();
        test_start_ignored();
        test_reset_mid();
        test_saturate();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
